// File: rtl/fdiv_prep.sv
// rtl/fdiv_prep.sv - single-precision divide front end: operand classification, denormal normalization, divider issue
module fdiv_prep (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic        busy,
   output logic        div_start,
   output logic [22:0] div_fx,
   output logic [22:0] div_fy,
   output logic [9:0]  div_exp,
   output logic        div_sign,
   input  logic        div_done,
   output logic        byp_valid,
   output logic [31:0] byp_rslt,
   output logic [4:0]  byp_flag
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLASS = 3'd1,
      NORM  = 3'd2,
      ISSUE = 3'd3,
      WAIT  = 3'd4
   } state_t;

   localparam logic [31:0] QNAN = 32'h7FC00000;

   state_t             state;
   logic [31:0]        xr;
   logic [31:0]        yr;
   logic [23:0]        mx;
   logic [23:0]        my;
   logic signed [11:0] ex;
   logic signed [11:0] ey;

   // operand classification of the latched operands
   logic x_exp_max, x_exp_zero, x_frac_nz;
   logic y_exp_max, y_exp_zero, y_frac_nz;
   logic x_nan, x_snan, x_inf, x_zero, x_den;
   logic y_nan, y_snan, y_inf, y_zero, y_den;
   logic q_sign;

   assign x_exp_max  = &xr[30:23];
   assign x_exp_zero = ~|xr[30:23];
   assign x_frac_nz  = |xr[22:0];
   assign y_exp_max  = &yr[30:23];
   assign y_exp_zero = ~|yr[30:23];
   assign y_frac_nz  = |yr[22:0];

   assign x_nan  = x_exp_max & x_frac_nz;
   assign x_snan = x_nan & ~xr[22];
   assign x_inf  = x_exp_max & ~x_frac_nz;
   assign x_zero = x_exp_zero & ~x_frac_nz;
   assign x_den  = x_exp_zero & x_frac_nz;
   assign y_nan  = y_exp_max & y_frac_nz;
   assign y_snan = y_nan & ~yr[22];
   assign y_inf  = y_exp_max & ~y_frac_nz;
   assign y_zero = y_exp_zero & ~y_frac_nz;
   assign y_den  = y_exp_zero & y_frac_nz;
   assign q_sign = xr[31] ^ yr[31];

   // denormals behave as exponent 1 with no hidden bit
   logic signed [11:0] x_eff;
   logic signed [11:0] y_eff;
   logic [23:0]        x_man;
   logic [23:0]        y_man;

   assign x_eff = x_den ? 12'sd1 : $signed({4'd0, xr[30:23]});
   assign y_eff = y_den ? 12'sd1 : $signed({4'd0, yr[30:23]});
   assign x_man = {~x_exp_zero, xr[22:0]};
   assign y_man = {~y_exp_zero, yr[22:0]};

   // one normalization step: only a mantissa lacking its leading 1 moves
   logic [23:0]        mx_sh;
   logic [23:0]        my_sh;
   logic signed [11:0] ex_sh;
   logic signed [11:0] ey_sh;

   assign mx_sh = mx[23] ? mx : {mx[22:0], 1'b0};
   assign my_sh = my[23] ? my : {my[22:0], 1'b0};
   assign ex_sh = mx[23] ? ex : ex - 12'sd1;
   assign ey_sh = my[23] ? ey : ey - 12'sd1;

   // special-case result selection, highest priority first
   logic        spec_hit;
   logic [31:0] spec_rslt;
   logic [4:0]  spec_flag;

   always_comb begin
      spec_hit  = 1'b1;
      spec_rslt = QNAN;
      spec_flag = 5'b00000;
      if (x_nan | y_nan) begin
         spec_flag = {x_snan | y_snan, 4'b0000};
      end else if ((x_zero & y_zero) | (x_inf & y_inf)) begin
         spec_flag = 5'b10000;
      end else if (y_zero & ~x_inf) begin
         spec_rslt = {q_sign, 8'hFF, 23'd0};
         spec_flag = 5'b01000;
      end else if (x_inf) begin
         spec_rslt = {q_sign, 8'hFF, 23'd0};
      end else if (y_inf | x_zero) begin
         spec_rslt = {q_sign, 31'd0};
      end else begin
         spec_hit  = 1'b0;
      end
   end

   // control FSM with all outputs registered alongside the state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         xr        <= '0;
         yr        <= '0;
         mx        <= '0;
         my        <= '0;
         ex        <= '0;
         ey        <= '0;
         busy      <= 1'b0;
         div_start <= 1'b0;
         div_fx    <= '0;
         div_fy    <= '0;
         div_exp   <= '0;
         div_sign  <= 1'b0;
         byp_valid <= 1'b0;
         byp_rslt  <= '0;
         byp_flag  <= '0;
      end else begin
         div_start <= 1'b0;
         byp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  xr    <= x;
                  yr    <= y;
                  busy  <= 1'b1;
                  state <= CLASS;
               end
            end
            CLASS: begin
               mx <= x_man;
               my <= y_man;
               ex <= x_eff;
               ey <= y_eff;
               if (spec_hit) begin
                  byp_valid <= 1'b1;
                  byp_rslt  <= spec_rslt;
                  byp_flag  <= spec_flag;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (x_den | y_den) begin
                  state <= NORM;
               end else begin
                  div_start <= 1'b1;
                  div_fx    <= xr[22:0];
                  div_fy    <= yr[22:0];
                  div_exp   <= 10'(x_eff - y_eff + 12'sd127);
                  div_sign  <= q_sign;
                  state     <= ISSUE;
               end
            end
            NORM: begin
               mx <= mx_sh;
               my <= my_sh;
               ex <= ex_sh;
               ey <= ey_sh;
               if (mx_sh[23] & my_sh[23]) begin
                  div_start <= 1'b1;
                  div_fx    <= mx_sh[22:0];
                  div_fy    <= my_sh[22:0];
                  div_exp   <= 10'(ex_sh - ey_sh + 12'sd127);
                  div_sign  <= q_sign;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (div_done) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fdiv_prep.sv
// tb/tb_fdiv_prep.sv - directed self-checking bench for fdiv_prep
module tb_fdiv_prep;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0;
   logic [31:0] x = '0;
   logic [31:0] y = '0;
   logic        div_done = 1'b0;
   logic        busy;
   logic        div_start;
   logic [22:0] div_fx;
   logic [22:0] div_fy;
   logic [9:0]  div_exp;
   logic        div_sign;
   logic        byp_valid;
   logic [31:0] byp_rslt;
   logic [4:0]  byp_flag;

   int errors = 0;
   int checks = 0;

   fdiv_prep dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .x         (x),
      .y         (y),
      .busy      (busy),
      .div_start (div_start),
      .div_fx    (div_fx),
      .div_fy    (div_fy),
      .div_exp   (div_exp),
      .div_sign  (div_sign),
      .div_done  (div_done),
      .byp_valid (byp_valid),
      .byp_rslt  (byp_rslt),
      .byp_flag  (byp_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, expv);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      x   = a;
      y   = b;
      req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
   endtask

   // edges after acceptance until the first output pulse; -1 if none within the budget
   task automatic wait_pulse(output int n, output logic st, output logic bp);
      n  = -1;
      st = 1'b0;
      bp = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (div_start || byp_valid) begin
            n  = i;
            st = div_start;
            bp = byp_valid;
            break;
         end
      end
   endtask

   task automatic finish_div(input string tag);
      @(negedge clk);
      div_done = 1'b1;
      @(posedge clk);
      #1;
      div_done = 1'b0;
      check(tag, busy, 1'b0);
   endtask

   task automatic div_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int n_exp, input logic [22:0] fx, input logic [22:0] fy,
                           input logic [9:0] ex, input logic sg);
      int   n;
      logic st, bp;
      issue(a, b);
      wait_pulse(n, st, bp);
      check({tag, "_lat"}, n, n_exp);
      check({tag, "_start"}, st, 1'b1);
      check({tag, "_byp"}, bp, 1'b0);
      check({tag, "_fx"}, div_fx, fx);
      check({tag, "_fy"}, div_fy, fy);
      check({tag, "_exp"}, div_exp, ex);
      check({tag, "_sign"}, div_sign, sg);
      @(posedge clk);
      #1;
      check({tag, "_start1"}, div_start, 1'b0);
      finish_div({tag, "_done"});
   endtask

   task automatic byp_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic [4:0] f);
      int   n;
      logic st, bp;
      issue(a, b);
      wait_pulse(n, st, bp);
      check({tag, "_lat"}, n, 1);
      check({tag, "_byp"}, bp, 1'b1);
      check({tag, "_start"}, st, 1'b0);
      check({tag, "_rslt"}, byp_rslt, r);
      check({tag, "_flag"}, byp_flag, f);
      check({tag, "_busy"}, busy, 1'b0);
      @(posedge clk);
      #1;
      check({tag, "_byp1"}, byp_valid, 1'b0);
   endtask

   initial begin
      int   n;
      logic st, bp;
      logic saw;

      // held in reset
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_start", div_start, 1'b0);
      check("rst_byp", byp_valid, 1'b0);
      check("rst_exp", div_exp, 10'd0);

      // first edge after release accepts the request
      @(negedge clk);
      reset = 1'b1;
      x     = 32'h40400000;
      y     = 32'h3F800000;
      req   = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      check("first_busy", busy, 1'b1);
      wait_pulse(n, st, bp);
      check("first_lat", n, 1);
      check("first_start", st, 1'b1);
      check("first_byp", bp, 1'b0);
      check("first_fx", div_fx, 23'h400000);
      check("first_fy", div_fy, 23'h000000);
      check("first_exp", div_exp, 10'h080);
      check("first_sign", div_sign, 1'b0);
      @(posedge clk);
      #1;
      check("first_start1", div_start, 1'b0);
      check("first_busy_wait", busy, 1'b1);

      // requests during WAIT are ignored
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         x   = 32'h7F800001;
         y   = 32'h00000000;
         req = 1'b1;
         @(posedge clk);
         #1;
         check("wait_req_start", div_start, 1'b0);
         check("wait_req_byp", byp_valid, 1'b0);
         check("wait_req_fx", div_fx, 23'h400000);
         check("wait_req_busy", busy, 1'b1);
      end
      req = 1'b0;
      finish_div("first_done");

      // denormal dividend needs 23 normalization steps
      div_case("den_x", 32'h00000001, 32'h3F800000, 24, 23'h0, 23'h0, 10'h3EA, 1'b0);
      // denormal divisor with one step
      div_case("den_y", 32'h3F800000, 32'h00400000, 2, 23'h0, 23'h0, 10'h0FE, 1'b0);
      // negative quotient, both normal
      div_case("neg", 32'hC0000000, 32'h40400000, 1, 23'h0, 23'h400000, 10'h07F, 1'b1);
      // largest exponent: 254 - (-22) + 127 = 403
      div_case("exp_max", 32'h7F7FFFFF, 32'h00000001, 24, 23'h7FFFFF, 23'h0, 10'h193, 1'b0);

      byp_case("dz", 32'h3F800000, 32'h80000000, 32'hFF800000, 5'b01000);
      byp_case("snan", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000);
      byp_case("zz", 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000);
      byp_case("qnan", 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00000);
      byp_case("snan_y0", 32'h00000000, 32'h7F800001, 32'h7FC00000, 5'b10000);
      byp_case("infinf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000);
      byp_case("inf_fin", 32'hFF800000, 32'h3F800000, 32'hFF800000, 5'b00000);
      byp_case("inf_zero", 32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000);
      byp_case("fin_inf", 32'h3F800000, 32'hFF800000, 32'h80000000, 5'b00000);
      byp_case("zero_fin", 32'h80000000, 32'hC0000000, 32'h00000000, 5'b00000);

      // reset in the middle of normalization
      issue(32'h00000001, 32'h3F800000);
      repeat (5) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_start", div_start, 1'b0);
      check("mid_rst_exp", div_exp, 10'd0);
      check("mid_rst_fx", div_fx, 23'd0);
      check("mid_rst_rslt", byp_rslt, 32'd0);
      check("mid_rst_flag", byp_flag, 5'd0);
      @(negedge clk);
      reset = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (div_start || byp_valid || busy) saw = 1'b1;
      end
      check("mid_rst_quiet", saw, 1'b0);

      div_case("after_rst", 32'h40400000, 32'h3F800000, 1, 23'h400000, 23'h0, 10'h080, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
